// File: rtl/flash_cmd_decode_if.sv
// rtl/flash_cmd_decode_if.sv - pin bundle between the flash bus front end and the command decoder
//
// Purpose: groups the chip-select/data lines and the decoder outputs so the
// decoder and whatever drives it share one port.
//   master : drives cs_n, mode, sio_in; observes the decoder outputs
//   slave  : the decoder side (flash_cmd_decode)
// Signals:
//   cs_n          chip select, active low
//   mode          0 = SPI (bit on sio_in[0]), 1 = OPI (byte on sio_in)
//   sio_in[7:0]   serial/octal input lines
//   en_addr       address phase active
//   en_write_buf  one-cycle strobe per completed write byte
//   en_read_buf   one-cycle strobe per read byte boundary
//   wr_data[7:0]  last completed write byte
//   opcode[7:0]   latched opcode of the current frame
//   wel           write-enable latch
//   prog_req      one-cycle page program request
//   cmd_err       unknown opcode in the current frame
interface flash_cmd_decode_if;
  logic       cs_n;
  logic       mode;
  logic [7:0] sio_in;
  logic       en_addr;
  logic       en_write_buf;
  logic       en_read_buf;
  logic [7:0] wr_data;
  logic [7:0] opcode;
  logic       wel;
  logic       prog_req;
  logic       cmd_err;

  modport master (
    output cs_n, mode, sio_in,
    input  en_addr, en_write_buf, en_read_buf, wr_data, opcode, wel, prog_req, cmd_err
  );

  modport slave (
    input  cs_n, mode, sio_in,
    output en_addr, en_write_buf, en_read_buf, wr_data, opcode, wel, prog_req, cmd_err
  );
endinterface

// File: rtl/flash_cmd_decode.sv
// rtl/flash_cmd_decode.sv - sck-domain opcode/address/dummy/data framing for the flash slave
//
// Purpose: captures the opcode (SPI bit-serial or OPI byte-wide), times the
// address phase, inserts fast-read dummy cycles, frames write/read data bytes,
// and owns the write-enable latch and the page program request.
// Optional feature: define FAST_READ_EN to decode 0x0B (fast read) with a
// DUMMY phase; without it 0x0B is an unknown opcode.
// Ports:
//   sck     in   serial clock, all state on posedge
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of flash_cmd_decode_if (cs_n/mode/sio_in in,
//           en_addr/en_write_buf/en_read_buf/wr_data/opcode/wel/prog_req/cmd_err out)
// Parameters:
//   ADDR_BYTES    address bytes per command (SPI 8*ADDR_BYTES cycles, OPI ADDR_BYTES)
//   DUMMY_CYCLES  fast-read dummy cycles
module flash_cmd_decode #(
  parameter int ADDR_BYTES   = 4,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic               sck,
  input  logic               rst_n,
  flash_cmd_decode_if.slave  bus
);
  localparam int CNT_MAX = (8 * ADDR_BYTES > DUMMY_CYCLES) ? 8 * ADDR_BYTES : DUMMY_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ADDR_LAST_SPI = CW'(8 * ADDR_BYTES - 1);
  localparam logic [CW-1:0] ADDR_LAST_OPI = CW'(ADDR_BYTES - 1);

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
`ifdef FAST_READ_EN
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
`ifdef FAST_READ_EN
    DUMMY,
`endif
    DATA_W,
    DATA_R,
    IGNORE
  } state_t;

  function automatic logic op_known(input logic [7:0] op);
    case (op)
      OP_PP, OP_READ, OP_RDSR, OP_WREN, OP_WRDI: op_known = 1'b1;
`ifdef FAST_READ_EN
      OP_FREAD: op_known = 1'b1;
`endif
      default: op_known = 1'b0;
    endcase
  endfunction

  function automatic state_t op_next(input logic [7:0] op);
    case (op)
      OP_PP, OP_READ: op_next = ADDR;
`ifdef FAST_READ_EN
      OP_FREAD: op_next = ADDR;
`endif
      OP_RDSR: op_next = DATA_R;
      default: op_next = IGNORE;
    endcase
  endfunction

  state_t        state;
  logic          frame_mode;
  logic [6:0]    shreg;
  logic [2:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic [8:0]    byte_cnt;
  logic          addr_done;
  logic          en_addr_q, en_write_buf_q, en_read_buf_q, wel_q, prog_req_q, cmd_err_q;
  logic [7:0]    wr_data_q, opcode_q;

  // The opcode is complete on the first OPI edge or on the 8th SPI bit; in IDLE
  // the frame mode register is not loaded yet, so the live mode input is used.
  logic       decode_now;
  logic       cur_opi;
  logic [7:0] op_now;
  state_t     dec_state;

  assign cur_opi    = (state == IDLE) ? bus.mode : frame_mode;
  assign op_now     = (state == IDLE) ? bus.sio_in : {shreg, bus.sio_in[0]};
  assign decode_now = ((state == IDLE) && bus.mode) || ((state == CMD) && (bitcnt == 3'd7));
  assign dec_state  = op_next(op_now);

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      frame_mode     <= 1'b0;
      shreg          <= '0;
      bitcnt         <= '0;
      cnt            <= '0;
      byte_cnt       <= '0;
      addr_done      <= 1'b0;
      en_addr_q      <= 1'b0;
      en_write_buf_q <= 1'b0;
      en_read_buf_q  <= 1'b0;
      wr_data_q      <= '0;
      opcode_q       <= '0;
      wel_q          <= 1'b0;
      prog_req_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      prog_req_q     <= 1'b0;
      en_write_buf_q <= 1'b0;
      en_read_buf_q  <= 1'b0;
      if (bus.cs_n) begin
        if (state != IDLE) begin
          state     <= IDLE;
          cnt       <= '0;
          bitcnt    <= '0;
          byte_cnt  <= '0;
          addr_done <= 1'b0;
          en_addr_q <= 1'b0;
          cmd_err_q <= 1'b0;
          if (opcode_q == OP_WREN) begin
            wel_q <= 1'b1;
          end else if (opcode_q == OP_WRDI) begin
            wel_q <= 1'b0;
          end else if (opcode_q == OP_PP && wel_q && addr_done && byte_cnt != 9'd0) begin
            prog_req_q <= 1'b1;
            wel_q      <= 1'b0;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            frame_mode <= bus.mode;
            if (!bus.mode) begin
              shreg  <= {6'b0, bus.sio_in[0]};
              bitcnt <= 3'd1;
              state  <= CMD;
            end
          end
          CMD: begin
            shreg  <= {shreg[5:0], bus.sio_in[0]};
            bitcnt <= bitcnt + 1'b1;
          end
          ADDR: begin
            if (cnt == (frame_mode ? ADDR_LAST_OPI : ADDR_LAST_SPI)) begin
              en_addr_q <= 1'b0;
              addr_done <= 1'b1;
              cnt       <= '0;
              bitcnt    <= '0;
              if (opcode_q == OP_PP) begin
                state <= DATA_W;
`ifdef FAST_READ_EN
              end else if (opcode_q == OP_FREAD && DUMMY_CYCLES != 0) begin
                state <= DUMMY;
`endif
              end else begin
                state         <= DATA_R;
                en_read_buf_q <= frame_mode;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef FAST_READ_EN
          DUMMY: begin
            if (cnt == DUMMY_LAST) begin
              state         <= DATA_R;
              cnt           <= '0;
              bitcnt        <= '0;
              en_read_buf_q <= frame_mode;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          DATA_W: begin
            if (frame_mode) begin
              wr_data_q      <= bus.sio_in;
              en_write_buf_q <= 1'b1;
              if (byte_cnt != 9'd256) byte_cnt <= byte_cnt + 1'b1;
            end else begin
              shreg  <= {shreg[5:0], bus.sio_in[0]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 3'd7) begin
                wr_data_q      <= {shreg, bus.sio_in[0]};
                en_write_buf_q <= 1'b1;
                if (byte_cnt != 9'd256) byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          DATA_R: begin
            // SPI: bitcnt==6 here means the next cycle is the 8th of the byte.
            bitcnt        <= bitcnt + 1'b1;
            en_read_buf_q <= frame_mode || (bitcnt == 3'd6);
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase

        if (decode_now) begin
          opcode_q      <= op_now;
          state         <= dec_state;
          en_addr_q     <= (dec_state == ADDR);
          cmd_err_q     <= !op_known(op_now);
          cnt           <= '0;
          bitcnt        <= '0;
          en_read_buf_q <= (dec_state == DATA_R) && cur_opi;
        end
      end
    end
  end

  assign bus.en_addr      = en_addr_q;
  assign bus.en_write_buf = en_write_buf_q;
  assign bus.en_read_buf  = en_read_buf_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.opcode       = opcode_q;
  assign bus.wel          = wel_q;
  assign bus.prog_req     = prog_req_q;
  assign bus.cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_flash_cmd_decode.sv
// tb/tb_flash_cmd_decode.sv - directed and randomized frames for flash_cmd_decode against a frame-level model
//
// Purpose: drives whole SPI/OPI frames, counts what the decoder emits per
// frame and compares it with counts derived from the frame description.
// Honours FAST_READ_EN the same way as the design.
// Ports: none (top-level bench).
module tb_flash_cmd_decode;
  localparam int ADDR_BYTES   = 4;
  localparam int DUMMY_CYCLES = 8;
`ifdef FAST_READ_EN
  localparam bit FR = 1'b1;
`else
  localparam bit FR = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic sck;
  logic rst_n;
  flash_cmd_decode_if bus ();

  flash_cmd_decode #(.ADDR_BYTES(ADDR_BYTES), .DUMMY_CYCLES(DUMMY_CYCLES)) dut (
    .sck   (sck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_idx = 0;
  int   frame_base = 0;
  logic exp_wel = 1'b0;

  // Per-frame observations, gathered on the falling edge.
  logic mon_en = 1'b0;
  int   addr_cnt, rd_cnt, prog_cnt, first_rd;
  logic err_seen;
  bq_t  wq;

  always @(negedge sck) begin
    if (mon_en) begin
      if (bus.en_addr) addr_cnt++;
      if (bus.en_write_buf) wq.push_back(bus.wr_data);
      if (bus.en_read_buf) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = edge_idx - frame_base;
      end
      if (bus.prog_req) prog_cnt++;
      if (bus.cmd_err) err_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic edge_in(input logic cs, input logic md, input logic [7:0] d);
    bus.cs_n   = cs;
    bus.mode   = md;
    bus.sio_in = d;
    @(posedge sck);
    edge_idx++;
    #1;
  endtask

  task automatic run_frame(input logic md, input logic [7:0] op, input int addr_units,
                           input bq_t data, input int partial, input int rd_cycles, input logic flip);
    int   n_addr, sent, op_units, dummy, exp_rd, exp_first, exp_addr;
    logic has_addr, addr_ok, known, is_rd, is_fr, reaches, mfr, exp_prog;
    logic [7:0] b;
    bq_t  exp_w;

    is_fr    = (op == 8'h0B) && FR;
    known    = (op inside {8'h02, 8'h03, 8'h04, 8'h05, 8'h06}) || is_fr;
    has_addr = (op == 8'h02) || (op == 8'h03) || is_fr;
    is_rd    = (op == 8'h03) || (op == 8'h05) || is_fr;
    n_addr   = md ? ADDR_BYTES : 8 * ADDR_BYTES;
    sent     = !has_addr ? 0 : ((addr_units < 0 || addr_units >= n_addr) ? n_addr : addr_units);
    addr_ok  = has_addr && (sent == n_addr);
    reaches  = has_addr ? addr_ok : 1'b1;
    op_units = md ? 1 : 8;
    dummy    = is_fr ? DUMMY_CYCLES : 0;
    mfr      = flip ? ~md : md;

    addr_cnt = 0; rd_cnt = 0; prog_cnt = 0; first_rd = -1; err_seen = 1'b0;
    wq.delete();
    frame_base = edge_idx + 1;
    mon_en = 1'b1;

    if (md) edge_in(1'b0, md, op);
    else for (int i = 7; i >= 0; i--) edge_in(1'b0, (i == 7) ? md : mfr, {7'($urandom), op[i]});
    for (int i = 0; i < sent; i++) edge_in(1'b0, mfr, 8'($urandom));
    if (reaches) begin
      if (op == 8'h02) begin
        foreach (data[i]) begin
          b = data[i];
          if (md) edge_in(1'b0, mfr, b);
          else for (int j = 7; j >= 0; j--) edge_in(1'b0, mfr, {7'($urandom), b[j]});
        end
        if (!md) for (int j = 0; j < partial; j++) edge_in(1'b0, mfr, 8'($urandom));
      end else begin
        for (int i = 0; i < dummy; i++) edge_in(1'b0, mfr, 8'($urandom));
        for (int i = 1; i < rd_cycles; i++) edge_in(1'b0, mfr, 8'($urandom));
      end
    end
    edge_in(1'b1, md, 8'($urandom));
    @(negedge sck);
    #1;
    mon_en = 1'b0;

    // Frame-level expectations.
    exp_addr  = !has_addr ? 0 : (addr_ok ? n_addr : sent + 1);
    exp_rd    = (is_rd && reaches) ? (md ? rd_cycles : rd_cycles / 8) : 0;
    exp_first = (exp_rd > 0) ? (op_units + sent + dummy - 1 + (md ? 0 : 7)) : -1;
    exp_w.delete();
    if (op == 8'h02 && addr_ok) exp_w = data;
    exp_prog = (op == 8'h02) && exp_wel && addr_ok && (data.size() >= 1);

    check("addr_cycles", addr_cnt, exp_addr);
    check("wr_count", wq.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (i < wq.size()) check("wr_data", {24'd0, wq[i]}, {24'd0, exp_w[i]});
    check("rd_count", rd_cnt, exp_rd);
    if (exp_rd > 0) check("rd_first", first_rd, exp_first);
    check("prog_req", prog_cnt, {31'd0, exp_prog});
    if (op == 8'h06) exp_wel = 1'b1;
    else if (op == 8'h04 || exp_prog) exp_wel = 1'b0;
    check("wel", {31'd0, bus.wel}, {31'd0, exp_wel});
    check("cmd_err_seen", {31'd0, err_seen}, {31'd0, !known});
    check("cmd_err_close", {31'd0, bus.cmd_err}, 32'd0);
    check("opcode_kept", {24'd0, bus.opcode}, {24'd0, op});
    check("strobes_close", {29'd0, bus.en_addr, bus.en_write_buf, bus.en_read_buf}, 32'd0);
    edge_in(1'b1, md, 8'h00);
  endtask

  initial begin
    bq_t q;
    logic [7:0] b;
    logic [7:0] op_tab[8];
    logic [7:0] op;
    logic md;

    rst_n = 1'b0;
    bus.cs_n = 1'b1; bus.mode = 1'b0; bus.sio_in = 8'h00;
    edge_in(1'b1, 1'b0, 8'h00);
    edge_in(1'b1, 1'b0, 8'h00);
    check("rst_outputs", {bus.en_addr, bus.en_write_buf, bus.en_read_buf, bus.wel,
                          bus.prog_req, bus.cmd_err, bus.wr_data, bus.opcode}, 32'd0);
    rst_n = 1'b1;
    edge_in(1'b1, 1'b0, 8'h00);

    q = {};
    run_frame(1'b0, 8'h06, -1, q, 0, 3, 1'b0);
    run_frame(1'b0, 8'h04, -1, q, 0, 3, 1'b0);
    run_frame(1'b0, 8'h06, -1, q, 0, 1, 1'b0);
    q = {8'hA5, 8'h3C};
    run_frame(1'b0, 8'h02, -1, q, 0, 1, 1'b0);
    q = {};
    run_frame(1'b1, 8'h03, -1, q, 0, 5, 1'b0);
    run_frame(1'b0, 8'h0B, -1, q, 0, 17, 1'b0);
    q = {8'h11};
    run_frame(1'b0, 8'h02, -1, q, 0, 1, 1'b0);
    run_frame(1'b0, 8'h06, -1, q, 0, 1, 1'b0);
    run_frame(1'b0, 8'h02, 10, q, 0, 1, 1'b0);
    q = {};
    run_frame(1'b0, 8'hFF, -1, q, 0, 6, 1'b0);
    run_frame(1'b1, 8'h05, -1, q, 0, 3, 1'b1);

    // Reset in the middle of a write data phase.
    run_frame(1'b0, 8'h06, -1, q, 0, 1, 1'b0);
    b = 8'h02;
    for (int j = 7; j >= 0; j--) edge_in(1'b0, 1'b0, {7'd0, b[j]});
    for (int i = 0; i < 8 * ADDR_BYTES; i++) edge_in(1'b0, 1'b0, 8'($urandom));
    b = 8'hA5;
    for (int j = 7; j >= 0; j--) edge_in(1'b0, 1'b0, {7'd0, b[j]});
    for (int j = 0; j < 4; j++) edge_in(1'b0, 1'b0, 8'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {bus.en_addr, bus.en_write_buf, bus.en_read_buf, bus.wel,
                        bus.prog_req, bus.cmd_err, bus.wr_data, bus.opcode}, 32'd0);
    bus.cs_n = 1'b1;
    @(posedge sck);
    #1;
    rst_n = 1'b1;
    exp_wel = 1'b0;
    edge_in(1'b1, 1'b0, 8'h00);

    op_tab = '{8'h02, 8'h03, 8'h05, 8'h06, 8'h04, 8'h0B, 8'hFF, 8'h00};
    for (int n = 0; n < 40; n++) begin
      op = op_tab[$urandom_range(7)];
      if (op == 8'h00) op = 8'($urandom);
      md = 1'($urandom);
      q = {};
      for (int i = $urandom_range(3); i > 0; i--) q.push_back(8'($urandom));
      run_frame(md, op, ($urandom_range(3) == 0) ? $urandom_range(md ? 3 : 31) : -1,
                q, $urandom_range(7), $urandom_range(1, 24), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
